// File: rtl/md_unit_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface md_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       func;
  logic             is_sign;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, func, is_sign, a, b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, func, is_sign, a, b, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle MULT/DIV unit owning HI/LO: pipelined multiply, restoring divide,
// flushable at any busy cycle, all outputs registered.
module md_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 3
) (
  input  logic      clk,
  input  logic      rst,
  md_unit_if.slave  md
);

  localparam logic [2:0] FUNC_MULT = 3'd1;
  localparam logic [2:0] FUNC_DIV  = 3'd2;
  localparam logic [2:0] FUNC_MTHI = 3'd3;
  localparam logic [2:0] FUNC_MTLO = 3'd4;

  // The shared counter must also reach MUL_CYCLES-1 when the multiply is deeper than WIDTH.
  localparam int DIV_CW = $clog2(WIDTH + 1);
  localparam int MUL_CW = $clog2(MUL_CYCLES + 1);
  localparam int CNT_W  = (DIV_CW > MUL_CW) ? DIV_CW : MUL_CW;

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [WIDTH-1:0]    hi_q, hi_d, lo_q, lo_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [2*WIDTH-1:0]  opA_q, opA_d, opB_q, opB_d;
  logic [WIDTH-1:0]    rem_q, rem_d, quo_q, quo_d, divisor_q, divisor_d;
  logic                negQuo_q, negQuo_d, negRem_q, negRem_d, divZero_q, divZero_d;

  logic [2*WIDTH-1:0]  extA, extB, product, mulResult;
  logic [WIDTH-1:0]    magA, magB;
  logic [WIDTH:0]      remShift, diff;

  assign extA = md.is_sign ? {{WIDTH{md.a[WIDTH-1]}}, md.a} : {{WIDTH{1'b0}}, md.a};
  assign extB = md.is_sign ? {{WIDTH{md.b[WIDTH-1]}}, md.b} : {{WIDTH{1'b0}}, md.b};
  assign magA = (md.is_sign && md.a[WIDTH-1]) ? (~md.a + 1'b1) : md.a;
  assign magB = (md.is_sign && md.b[WIDTH-1]) ? (~md.b + 1'b1) : md.b;

  assign product  = opA_q * opB_q;
  assign remShift = {rem_q, quo_q[WIDTH-1]};
  assign diff     = remShift - {1'b0, divisor_q};

  // HI/LO act as the final product stage, so only MUL_CYCLES-1 internal stages are needed.
  generate
    if (MUL_CYCLES == 1) begin : gNoPipe
      assign mulResult = product;
    end else begin : gPipe
      logic [2*WIDTH-1:0] mulPipe_q [MUL_CYCLES-1];
      always_ff @(posedge clk) begin
        mulPipe_q[0] <= product;
        for (int i = 1; i < MUL_CYCLES - 1; i++) begin
          mulPipe_q[i] <= mulPipe_q[i-1];
        end
      end
      assign mulResult = mulPipe_q[MUL_CYCLES-2];
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    opA_d     = opA_q;
    opB_d     = opB_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    negQuo_d  = negQuo_q;
    negRem_d  = negRem_q;
    divZero_d = divZero_q;

    case (state_q)
      IDLE: begin
        if (md.start && !md.flush) begin
          case (md.func)
            FUNC_MULT: begin
              opA_d   = extA;
              opB_d   = extB;
              count_d = '0;
              state_d = MUL;
            end
            FUNC_DIV: begin
              quo_d     = magA;
              rem_d     = '0;
              divisor_d = magB;
              negQuo_d  = md.is_sign & (md.a[WIDTH-1] ^ md.b[WIDTH-1]);
              negRem_d  = md.is_sign & md.a[WIDTH-1];
              divZero_d = (md.b == '0);
              count_d   = '0;
              state_d   = DIV;
            end
            FUNC_MTHI: hi_d = md.a;
            FUNC_MTLO: lo_d = md.a;
            default: ;
          endcase
        end
      end
      MUL: begin
        if (md.flush) begin
          state_d = IDLE;
          count_d = '0;
        end else if (count_q == MUL_LAST) begin
          hi_d    = mulResult[2*WIDTH-1:WIDTH];
          lo_d    = mulResult[WIDTH-1:0];
          done_d  = 1'b1;
          state_d = IDLE;
          count_d = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      DIV: begin
        if (md.flush) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          // Restoring step: keep the subtraction only when it did not borrow.
          if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = remShift[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          if (count_q == DIV_LAST) begin
            state_d = FIX;
            count_d = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      FIX: begin
        state_d = IDLE;
        count_d = '0;
        if (!md.flush) begin
          lo_d   = divZero_q ? '1 : (negQuo_q ? (~quo_q + 1'b1) : quo_q);
          hi_d   = negRem_q ? (~rem_q + 1'b1) : rem_q;
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      opA_q     <= '0;
      opB_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      negQuo_q  <= 1'b0;
      negRem_q  <= 1'b0;
      divZero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      opA_q     <= opA_d;
      opB_q     <= opB_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      negQuo_q  <= negQuo_d;
      negRem_q  <= negRem_d;
      divZero_q <= divZero_d;
    end
  end

  assign md.busy = busy_q;
  assign md.done = done_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Randomised and directed bench for md_unit against a plain-arithmetic HI/LO model.
module tb_md_unit;

  localparam int W  = 32;
  localparam int MC = 3;

  localparam logic [2:0] F_MULT = 3'd1;
  localparam logic [2:0] F_DIV  = 3'd2;
  localparam logic [2:0] F_MTHI = 3'd3;
  localparam logic [2:0] F_MTLO = 3'd4;

  logic clk = 1'b0;
  logic rst;

  md_unit_if #(.WIDTH(W)) mdIf ();

  md_unit #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
    .clk (clk),
    .rst (rst),
    .md  (mdIf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  logic [W-1:0] modelHi = '0;
  logic [W-1:0] modelLo = '0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Expected HI/LO from 64-bit integer arithmetic, plus the latency of the op.
  task automatic predict(input logic [2:0] f, input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] eh, output logic [W-1:0] el, output int lat);
    longint sx, sy, q, r;
    logic [63:0] bits;
    sx  = s ? longint'($signed(x)) : longint'({32'b0, x});
    sy  = s ? longint'($signed(y)) : longint'({32'b0, y});
    eh  = modelHi;
    el  = modelLo;
    lat = 0;
    case (f)
      F_MULT: begin
        bits = sx * sy;
        eh   = bits[63:32];
        el   = bits[31:0];
        lat  = MC;
      end
      F_DIV: begin
        lat = W + 1;
        if (y == '0) begin
          el = '1;
          eh = x;
        end else begin
          q    = sx / sy;
          r    = sx % sy;
          bits = q;
          el   = bits[31:0];
          bits = r;
          eh   = bits[31:0];
        end
      end
      F_MTHI: eh = x;
      F_MTLO: el = x;
      default: ;
    endcase
  endtask

  // Issue one op at the next edge and follow it to completion or flush; called at a negedge.
  task automatic applyStimulus(input logic [2:0] f, input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                               input int flushAt, input bit pester);
    logic [W-1:0] eh, el;
    int lat, busyCycles, cyc;
    bit bad;
    predict(f, s, x, y, eh, el, lat);
    mdIf.start = 1'b1; mdIf.func = f; mdIf.is_sign = s; mdIf.a = x; mdIf.b = y; mdIf.flush = 1'b0;
    @(negedge clk);
    mdIf.start = pester;
    if (pester) begin
      mdIf.func = F_MULT; mdIf.a = $urandom; mdIf.b = $urandom;
    end
    if (f == F_MTHI || f == F_MTLO) begin
      modelHi = eh;
      modelLo = el;
      checkOutput("mt_hi", mdIf.hi, modelHi);
      checkOutput("mt_lo", mdIf.lo, modelLo);
      checkOutput("mt_busy", mdIf.busy, 0);
      checkOutput("mt_done", mdIf.done, 0);
      return;
    end
    if (flushAt > 0) begin
      bad = 0;
      for (int c = 1; c < flushAt; c++) begin
        if (!mdIf.busy || mdIf.done) bad = 1;
        @(negedge clk);
      end
      if (!mdIf.busy) bad = 1;
      checkOutput("busy_before_flush", bad, 0);
      mdIf.flush = 1'b1;
      @(negedge clk);
      mdIf.flush = 1'b0;
      mdIf.start = 1'b0;
      checkOutput("flush_busy", mdIf.busy, 0);
      checkOutput("flush_done", mdIf.done, 0);
      checkOutput("flush_hi", mdIf.hi, modelHi);
      checkOutput("flush_lo", mdIf.lo, modelLo);
      bad = 0;
      repeat (3) begin
        @(negedge clk);
        if (mdIf.done || mdIf.busy) bad = 1;
      end
      checkOutput("quiet_after_flush", bad, 0);
      return;
    end
    busyCycles = 0;
    cyc        = 0;
    bad        = 0;
    while (!mdIf.done && cyc < lat + 5) begin
      if (mdIf.busy) busyCycles++;
      if (mdIf.hi !== modelHi || mdIf.lo !== modelLo) bad = 1;
      cyc++;
      @(negedge clk);
    end
    mdIf.start = 1'b0;
    modelHi    = eh;
    modelLo    = el;
    checkOutput("done_seen", mdIf.done, 1);
    checkOutput("busy_cycles", busyCycles, lat);
    checkOutput("busy_at_done", mdIf.busy, 0);
    checkOutput("hold_while_busy", bad, 0);
    checkOutput("result_hi", mdIf.hi, modelHi);
    checkOutput("result_lo", mdIf.lo, modelLo);
    @(negedge clk);
    checkOutput("done_one_cycle", mdIf.done, 0);
    checkOutput("idle_after_done", mdIf.busy, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0]   f;
    logic         s;
    logic [W-1:0] x, y;
    int           fl, lat;
    bit           bad;

    mdIf.start = 1'b0; mdIf.func = 3'd0; mdIf.is_sign = 1'b0;
    mdIf.a = '0; mdIf.b = '0; mdIf.flush = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_hi", mdIf.hi, 0);
    checkOutput("reset_lo", mdIf.lo, 0);
    checkOutput("reset_busy", mdIf.busy, 0);
    checkOutput("reset_done", mdIf.done, 0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(F_MULT, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    checkOutput("umul_ff_hi", mdIf.hi, 32'hFFFFFFFE);
    checkOutput("umul_ff_lo", mdIf.lo, 32'h00000001);
    applyStimulus(F_MULT, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    checkOutput("smul_ff_hi", mdIf.hi, 32'h0);
    checkOutput("smul_ff_lo", mdIf.lo, 32'h1);
    applyStimulus(F_MULT, 1'b1, 32'hFFFFFFFD, 32'd5, 0, 0);
    checkOutput("smul_m3x5_hi", mdIf.hi, 32'hFFFFFFFF);
    checkOutput("smul_m3x5_lo", mdIf.lo, 32'hFFFFFFF1);
    applyStimulus(F_DIV, 1'b1, 32'hFFFFFFF9, 32'd2, 0, 1);
    checkOutput("sdiv_m7d2_lo", mdIf.lo, 32'hFFFFFFFD);
    checkOutput("sdiv_m7d2_hi", mdIf.hi, 32'hFFFFFFFF);
    applyStimulus(F_DIV, 1'b0, 32'd100, 32'd7, 0, 0);
    checkOutput("udiv_100d7_lo", mdIf.lo, 32'd14);
    checkOutput("udiv_100d7_hi", mdIf.hi, 32'd2);
    applyStimulus(F_DIV, 1'b0, 32'h12345678, 32'h0, 0, 0);
    checkOutput("udiv_zero_lo", mdIf.lo, 32'hFFFFFFFF);
    checkOutput("udiv_zero_hi", mdIf.hi, 32'h12345678);
    applyStimulus(F_DIV, 1'b1, 32'h87654321, 32'h0, 0, 0);
    checkOutput("sdiv_zero_lo", mdIf.lo, 32'hFFFFFFFF);
    checkOutput("sdiv_zero_hi", mdIf.hi, 32'h87654321);
    applyStimulus(F_DIV, 1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    checkOutput("sdiv_minneg_lo", mdIf.lo, 32'h80000000);
    checkOutput("sdiv_minneg_hi", mdIf.hi, 32'h0);
    applyStimulus(F_MTHI, 1'b0, 32'hA5A5A5A5, 32'h0, 0, 0);
    checkOutput("mthi_a5_hi", mdIf.hi, 32'hA5A5A5A5);
    applyStimulus(F_MTLO, 1'b0, 32'h3C3C0F0F, 32'h0, 0, 0);

    applyStimulus(F_DIV, 1'b0, 32'd1000, 32'd3, 10, 0);
    applyStimulus(F_DIV, 1'b1, 32'hFFFF0000, 32'd9, W + 1, 1);
    applyStimulus(F_MULT, 1'b0, 32'd1234, 32'd5678, MC, 0);

    // MTHI alongside flush in IDLE and invalid func codes must leave HI/LO alone.
    mdIf.start = 1'b1; mdIf.func = F_MTHI; mdIf.a = 32'h5A5A5A5A; mdIf.flush = 1'b1;
    @(negedge clk);
    mdIf.start = 1'b0; mdIf.flush = 1'b0;
    checkOutput("mthi_flush_hi", mdIf.hi, modelHi);
    mdIf.start = 1'b1; mdIf.func = 3'd5; mdIf.a = 32'h11111111;
    @(negedge clk);
    mdIf.func = 3'd0;
    @(negedge clk);
    mdIf.start = 1'b0;
    checkOutput("bad_func_busy", mdIf.busy, 0);
    checkOutput("bad_func_hi", mdIf.hi, modelHi);
    checkOutput("bad_func_lo", mdIf.lo, modelLo);

    mdIf.start = 1'b1; mdIf.func = F_MULT; mdIf.is_sign = 1'b0; mdIf.a = 32'd77; mdIf.b = 32'd99;
    @(negedge clk);
    mdIf.start = 1'b0;
    @(negedge clk);
    rst = 1'b1; mdIf.flush = 1'b1; mdIf.start = 1'b1; mdIf.func = F_MTHI;
    @(negedge clk);
    rst = 1'b0; mdIf.flush = 1'b0; mdIf.start = 1'b0;
    modelHi = '0;
    modelLo = '0;
    checkOutput("rst_mid_hi", mdIf.hi, 0);
    checkOutput("rst_mid_lo", mdIf.lo, 0);
    checkOutput("rst_mid_busy", mdIf.busy, 0);
    checkOutput("rst_mid_done", mdIf.done, 0);
    bad = 0;
    repeat (MC + 2) begin
      @(negedge clk);
      if (mdIf.done || mdIf.busy) bad = 1;
    end
    checkOutput("rst_mid_quiet", bad, 0);

    for (int n = 0; n < 40; n++) begin
      f = 3'($urandom_range(1, 4));
      s = 1'($urandom_range(0, 1));
      x = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
      case ($urandom_range(0, 5))
        0:       y = 32'h0;
        1:       y = 32'hFFFFFFFF;
        2:       y = 32'($urandom_range(1, 15));
        default: y = 32'($urandom);
      endcase
      lat = (f == F_MULT) ? MC : W + 1;
      fl  = 0;
      if ((f == F_MULT || f == F_DIV) && $urandom_range(0, 5) == 0) fl = $urandom_range(1, lat);
      applyStimulus(f, s, x, y, fl, (f == F_MULT || f == F_DIV) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
